// File: rtl/pc_next_ctrl_if.sv
// Fetch-side signal bundle between the program-counter controller and the fetch stage.
// The master drives PC/hazard/redirect inputs; the slave (controller) drives PC and IF/ID controls.
interface pc_next_ctrl_if;
  logic [9:0] PC_current;
  logic       mem_busy;
  logic       load_use_hazard;
  logic       branch_taken;
  logic [9:0] branch_target;
  logic       jump;
  logic [9:0] jump_target;
  logic       PC_write;
  logic [9:0] PC_new;
  logic       IF_ID_write;
  logic       IF_ID_flush;

  modport master (
    output PC_current, mem_busy, load_use_hazard, branch_taken, branch_target,
           jump, jump_target,
    input  PC_write, PC_new, IF_ID_write, IF_ID_flush
  );

  modport slave (
    input  PC_current, mem_busy, load_use_hazard, branch_taken, branch_target,
           jump, jump_target,
    output PC_write, PC_new, IF_ID_write, IF_ID_flush
  );
endinterface

// File: rtl/pc_next_ctrl.sv
// Next-PC controller: sequential fetch, stalls, and redirects deferred while memory is busy.
// Optional macro PC_STALL_CNT_EN adds a saturating stall_count output.
//
// state  | meaning
// S_RUN  | normal fetch
// S_STALL| memory busy, sequential fetch held
// S_PEND | redirect latched in pending_target, waiting for memory
module pc_next_ctrl (
  input  logic            clock,
  input  logic            reset,
  pc_next_ctrl_if.slave   bus
`ifdef PC_STALL_CNT_EN
  ,
  output logic [15:0]     stall_count
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_PEND  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] pending_target, pending_nxt;
  logic       pc_write;
  logic [9:0] pc_new;
  logic       ifid_write;
  logic       ifid_flush;
  logic       redirect;
  logic [9:0] target;
  logic [9:0] seq_addr;

  assign redirect = bus.jump | bus.branch_taken;
  assign target   = bus.jump ? bus.jump_target : bus.branch_target;
  assign seq_addr = bus.PC_current + 10'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_RUN;
      pending_target <= 10'd0;
    end else begin
      state          <= state_nxt;
      pending_target <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending_target;
    pc_write    = 1'b0;
    pc_new      = bus.PC_current;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;

    case (state)
      S_RUN, S_STALL: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          ifid_write = 1'b1;
          // a redirect seen while stalled is always deferred, even if memory frees up
          if (state == S_RUN && !bus.mem_busy) begin
            pc_write = 1'b1;
            pc_new   = target;
          end else begin
            pending_nxt = target;
            state_nxt   = S_PEND;
          end
        end else if (bus.mem_busy) begin
          state_nxt = S_STALL;
        end else begin
          state_nxt = S_RUN;
          if (!bus.load_use_hazard) begin
            pc_write   = 1'b1;
            pc_new     = seq_addr;
            ifid_write = 1'b1;
          end
        end
      end
      S_PEND: begin
        ifid_flush = 1'b1;
        ifid_write = 1'b1;
        if (!bus.mem_busy) begin
          pc_write  = 1'b1;
          pc_new    = pending_target;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase

    if (reset) begin
      pc_write    = 1'b1;
      pc_new      = 10'd0;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      state_nxt   = S_RUN;
      pending_nxt = 10'd0;
    end
  end

  assign bus.PC_write    = pc_write;
  assign bus.PC_new      = pc_new;
  assign bus.IF_ID_write = ifid_write;
  assign bus.IF_ID_flush = ifid_flush;

`ifdef PC_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      stall_count <= 16'd0;
    else if (!pc_write && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: doc/pc_next_ctrl.md
PC_NEXT_CTRL -- requirements
Module: pc_next_ctrl

Interface
REQ-001 clock  input  1  single clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 PC_current  input  10  address currently held by the program counter (word address).
REQ-004 mem_busy  input  1  instruction memory cannot accept a new fetch address this cycle.
REQ-005 load_use_hazard  input  1  decode-stage load-use hazard; hold fetch for this cycle.
REQ-006 branch_taken  input  1  resolved taken branch this cycle.
REQ-007 branch_target  input  10  branch destination address.
REQ-008 jump  input  1  unconditional jump this cycle.
REQ-009 jump_target  input  10  jump destination address.
REQ-010 PC_write  output  1  load enable for the program counter.
REQ-011 PC_new  output  10  next address presented to the program counter.
REQ-012 IF_ID_write  output  1  IF/ID pipeline register load enable.
REQ-013 IF_ID_flush  output  1  replace IF/ID contents with a bubble.

Function
REQ-014 Outputs SHALL be combinational from current state and inputs (Mealy); the PC samples PC_new on the same edge that updates controller state.
REQ-015 Sequential address SHALL be PC_current+1, modulo 1024 (1023 -> 0, no carry out).
REQ-016 Redirect = jump OR branch_taken; target SHALL be jump_target if jump=1, else branch_target.
REQ-017 States SHALL be RUN, STALL, PEND; a 10-bit pending_target register SHALL hold a deferred redirect.
REQ-018 RUN, redirect, mem_busy=0: PC_write=1, PC_new=target, IF_ID_flush=1, IF_ID_write=1; stay RUN.
REQ-019 RUN, redirect, mem_busy=1: PC_write=0, IF_ID_flush=1, pending_target<=target; next PEND.
REQ-020 RUN, no redirect, mem_busy=1: PC_write=0, IF_ID_write=0; next STALL.
REQ-021 RUN, no redirect, mem_busy=0, load_use_hazard=1: PC_write=0, IF_ID_write=0, IF_ID_flush=0; stay RUN.
REQ-022 RUN, none of the above: PC_write=1, PC_new=PC_current+1, IF_ID_write=1, IF_ID_flush=0.
REQ-023 STALL, mem_busy=1, no redirect: PC_write=0, IF_ID_write=0; stay STALL.
REQ-024 STALL, redirect (any mem_busy): behave as REQ-019 (latch target, flush, next PEND).
REQ-025 STALL, mem_busy=0, no redirect: apply REQ-021/REQ-022 rules; next RUN.
REQ-026 PEND, mem_busy=1: PC_write=0, IF_ID_flush=1, IF_ID_write=1; stay PEND.
REQ-027 PEND, mem_busy=0: PC_write=1, PC_new=pending_target, IF_ID_flush=1; next RUN.
REQ-028 In PEND, redirect inputs and load_use_hazard SHALL be ignored (younger instructions are being flushed).
REQ-029 IF_ID_flush=1 SHALL take precedence over IF_ID_write at the IF/ID register.
REQ-030 Whenever PC_write=0, PC_new SHALL equal PC_current.

Reset
REQ-031 While reset=1: PC_write=1, PC_new=0, IF_ID_write=1, IF_ID_flush=1, regardless of other inputs.
REQ-032 Reset SHALL set state to RUN and pending_target to 0 on the next edge; reset in STALL or PEND SHALL discard any pending redirect.
REQ-033 First cycle after reset deasserts SHALL fetch from address 0 per RUN rules.

Configuration
REQ-034 Macro PC_STALL_CNT_EN defined: output stall_count [15:0] SHALL count cycles with reset=0 and PC_write=0, saturating at 65535, cleared by reset.
REQ-035 Macro PC_STALL_CNT_EN undefined: stall_count port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-036 PC_current=5, all hazard inputs 0 -> PC_write=1, PC_new=6; PC_current=1023 -> PC_new=0.
REQ-037 RUN, jump=1 jump_target=0x200, branch_taken=1 branch_target=0x010, mem_busy=0 -> PC_new=0x200, PC_write=1, IF_ID_flush=1.
REQ-038 RUN, branch_taken=1 target=0x040 with mem_busy=1 for 3 cycles -> PC_write=0 and flush=1 for 3 cycles, then PC_new=0x040, PC_write=1, state RUN; a jump during PEND is ignored.
REQ-039 load_use_hazard=1 one cycle at PC_current=8 -> PC_write=0, IF_ID_write=0, IF_ID_flush=0; next cycle PC_new=9.
REQ-040 Reset asserted while in PEND with pending 0x3FF -> PC_new=0, PC_write=1; after release, no jump to 0x3FF occurs.
REQ-041 With PC_STALL_CNT_EN: 4 mem_busy cycles plus 2 load-use cycles -> stall_count=6; reset -> 0.
